// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcode constants,
// the HALT instruction encoding, state enumeration, datapath select
// encodings and trap cause codes.
package multicycle_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   // EBREAK is used as the halt instruction; the decoder compares IR to it.
   localparam logic [31:0] HALT_INSTR = 32'h0010_0073;

   typedef enum logic [3:0] {
      RST,
      FETCH,
      DECODE,
      EX_R,
      EX_I,
      WB_ALU,
      MEM_ADDR,
      MEM_RD,
      WB_MEM,
      MEM_WR,
      BRANCH,
      JAL,
      JALR,
      HALT,
      TRAP
   } mc_state_e;

   localparam logic [1:0] ASEL_PC     = 2'd0;
   localparam logic [1:0] ASEL_RS1    = 2'd1;
   localparam logic [1:0] ASEL_OLDPC  = 2'd2;

   localparam logic [1:0] BSEL_RS2    = 2'd0;
   localparam logic [1:0] BSEL_FOUR   = 2'd1;
   localparam logic [1:0] BSEL_IMM    = 2'd2;

   localparam logic [1:0] AOP_ADD     = 2'd0;
   localparam logic [1:0] AOP_SUB     = 2'd1;
   localparam logic [1:0] AOP_FUNCT   = 2'd2;

   localparam logic [1:0] WB_ALUOUT   = 2'd0;
   localparam logic [1:0] WB_MDR      = 2'd1;
   localparam logic [1:0] WB_PC       = 2'd2;

   localparam logic [1:0] PCSRC_ALU      = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT   = 2'd1;
   localparam logic [1:0] PCSRC_ALU_MASK = 2'd2;

   localparam logic [1:0] TRAP_NONE    = 2'd0;
   localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
   localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

   // States in which a memory request is outstanding and mem_ready is awaited.
   function automatic logic is_mem_wait(input mc_state_e s);
      return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller (master) and the
// datapath/decoder/memory side (slave). The performance counter outputs
// exist only when MULTICYCLE_PERF_EN is defined.
interface multicycle_ctrl_if;

   logic [6:0] opcode;
   logic       instr_is_halt;
   logic       branch_cond;
   logic       mem_ready;

   logic       pc_wr_en;
   logic       ir_wr_en;
   logic       reg_wr_en;
   logic       mem_req;
   logic       mem_we;
   logic       mem_addr_sel;
   logic [1:0] alu_a_sel;
   logic [1:0] alu_b_sel;
   logic [1:0] alu_op_sel;
   logic [1:0] wb_sel;
   logic [1:0] pc_src;
   logic       halted;
   logic       trap;
   logic [1:0] trap_cause;

`ifdef MULTICYCLE_PERF_EN
   logic [31:0] cyc_cnt;
   logic [31:0] instret_cnt;
   logic [31:0] stall_cnt;
`endif

   modport master (
      input  opcode, instr_is_halt, branch_cond, mem_ready,
      output pc_wr_en, ir_wr_en, reg_wr_en, mem_req, mem_we, mem_addr_sel,
             alu_a_sel, alu_b_sel, alu_op_sel, wb_sel, pc_src,
             halted, trap, trap_cause
`ifdef MULTICYCLE_PERF_EN
      , output cyc_cnt, instret_cnt, stall_cnt
`endif
   );

   modport slave (
      output opcode, instr_is_halt, branch_cond, mem_ready,
      input  pc_wr_en, ir_wr_en, reg_wr_en, mem_req, mem_we, mem_addr_sel,
             alu_a_sel, alu_b_sel, alu_op_sel, wb_sel, pc_src,
             halted, trap, trap_cause
`ifdef MULTICYCLE_PERF_EN
      , input cyc_cnt, instret_cnt, stall_cnt
`endif
   );

endinterface

// File: rtl/multicycle_ctrl_mem_timeout.sv
// Memory wait timeout: counts consecutive cycles spent waiting for
// mem_ready and flags expiry on the TMO_CYC-th waiting cycle. A ready
// arriving on that same cycle suppresses the expiry.
module mc_mem_timeout #(
   parameter int TMO_CYC = 64,
   parameter int TMO_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic mem_ready,
   output logic expired
);

   logic [TMO_W-1:0] cnt;

   // Count waiting cycles; any cycle that is not a stalled wait restarts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (waiting && !mem_ready) begin
         cnt <= cnt + TMO_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   // Expire when the current stalled cycle is the TMO_CYC-th one.
   always_comb begin
      expired = waiting && !mem_ready && (cnt == TMO_W'(TMO_CYC - 1));
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset controller: a Moore FSM that schedules the
// shared ALU, unified memory and register writes state by state.
// Optional feature macro: MULTICYCLE_PERF_EN (cycle/instret/stall counters).
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TMO_CYC = 64,
   parameter int TMO_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   multicycle_ctrl_if.master  bus
);

   mc_state_e  state;
   mc_state_e  next_state;
   logic [1:0] cause_q;
   logic [1:0] cause_d;
   logic       waiting;
   logic       tmo_expired;

   assign waiting = is_mem_wait(state);

   mc_mem_timeout #(
      .TMO_CYC (TMO_CYC),
      .TMO_W   (TMO_W)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .waiting   (waiting),
      .mem_ready (bus.mem_ready),
      .expired   (tmo_expired)
   );

   // State and latched trap cause registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= RST;
         cause_q <= TRAP_NONE;
      end else begin
         state   <= next_state;
         cause_q <= cause_d;
      end
   end

   // Next-state selection, including decode dispatch and timeout traps.
   always_comb begin
      next_state = state;
      cause_d    = cause_q;
      unique case (state)
         RST:      next_state = FETCH;
         FETCH: begin
            if (bus.mem_ready) begin
               next_state = DECODE;
            end else if (tmo_expired) begin
               next_state = TRAP;
               cause_d    = TRAP_TIMEOUT;
            end
         end
         DECODE: begin
            if (bus.instr_is_halt) begin
               next_state = HALT;
            end else begin
               unique case (bus.opcode)
                  OP_R:                next_state = EX_R;
                  OP_IMM:              next_state = EX_I;
                  OP_LOAD, OP_STORE:   next_state = MEM_ADDR;
                  OP_BRANCH:           next_state = BRANCH;
                  OP_JAL:              next_state = JAL;
                  OP_JALR:             next_state = JALR;
                  default: begin
                     next_state = TRAP;
                     cause_d    = TRAP_ILLEGAL;
                  end
               endcase
            end
         end
         EX_R, EX_I: next_state = WB_ALU;
         WB_ALU:     next_state = FETCH;
         MEM_ADDR:   next_state = (bus.opcode == OP_STORE) ? MEM_WR : MEM_RD;
         MEM_RD: begin
            if (bus.mem_ready) begin
               next_state = WB_MEM;
            end else if (tmo_expired) begin
               next_state = TRAP;
               cause_d    = TRAP_TIMEOUT;
            end
         end
         WB_MEM:     next_state = FETCH;
         MEM_WR: begin
            if (bus.mem_ready) begin
               next_state = FETCH;
            end else if (tmo_expired) begin
               next_state = TRAP;
               cause_d    = TRAP_TIMEOUT;
            end
         end
         BRANCH, JAL, JALR: next_state = FETCH;
         HALT, TRAP:        next_state = state;
         default:           next_state = RST;
      endcase
   end

   // Per-state control schedule; the fetch strobes are qualified by the handshake.
   always_comb begin
      bus.pc_wr_en     = 1'b0;
      bus.ir_wr_en     = 1'b0;
      bus.reg_wr_en    = 1'b0;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr_sel = 1'b0;
      bus.alu_a_sel    = ASEL_PC;
      bus.alu_b_sel    = BSEL_RS2;
      bus.alu_op_sel   = AOP_ADD;
      bus.wb_sel       = WB_ALUOUT;
      bus.pc_src       = PCSRC_ALU;
      bus.halted       = 1'b0;
      bus.trap         = 1'b0;
      bus.trap_cause   = TRAP_NONE;
      unique case (state)
         FETCH: begin
            bus.mem_req   = 1'b1;
            bus.alu_a_sel = ASEL_PC;
            bus.alu_b_sel = BSEL_FOUR;
            bus.ir_wr_en  = bus.mem_ready;
            bus.pc_wr_en  = bus.mem_ready;
            bus.pc_src    = PCSRC_ALU;
         end
         DECODE: begin
            bus.alu_a_sel = ASEL_OLDPC;
            bus.alu_b_sel = BSEL_IMM;
         end
         EX_R: begin
            bus.alu_a_sel  = ASEL_RS1;
            bus.alu_b_sel  = BSEL_RS2;
            bus.alu_op_sel = AOP_FUNCT;
         end
         EX_I: begin
            bus.alu_a_sel  = ASEL_RS1;
            bus.alu_b_sel  = BSEL_IMM;
            bus.alu_op_sel = AOP_FUNCT;
         end
         WB_ALU: begin
            bus.reg_wr_en = 1'b1;
            bus.wb_sel    = WB_ALUOUT;
         end
         MEM_ADDR: begin
            bus.alu_a_sel = ASEL_RS1;
            bus.alu_b_sel = BSEL_IMM;
         end
         MEM_RD: begin
            bus.mem_req      = 1'b1;
            bus.mem_addr_sel = 1'b1;
         end
         WB_MEM: begin
            bus.reg_wr_en = 1'b1;
            bus.wb_sel    = WB_MDR;
         end
         MEM_WR: begin
            bus.mem_req      = 1'b1;
            bus.mem_we       = 1'b1;
            bus.mem_addr_sel = 1'b1;
         end
         BRANCH: begin
            bus.alu_a_sel  = ASEL_RS1;
            bus.alu_b_sel  = BSEL_RS2;
            bus.alu_op_sel = AOP_SUB;
            bus.pc_wr_en   = bus.branch_cond;
            bus.pc_src     = PCSRC_ALUOUT;
         end
         JAL: begin
            bus.reg_wr_en = 1'b1;
            bus.wb_sel    = WB_PC;
            bus.pc_wr_en  = 1'b1;
            bus.pc_src    = PCSRC_ALUOUT;
         end
         JALR: begin
            bus.alu_a_sel = ASEL_RS1;
            bus.alu_b_sel = BSEL_IMM;
            bus.reg_wr_en = 1'b1;
            bus.wb_sel    = WB_PC;
            bus.pc_wr_en  = 1'b1;
            bus.pc_src    = PCSRC_ALU_MASK;
         end
         HALT:    bus.halted = 1'b1;
         TRAP: begin
            bus.trap       = 1'b1;
            bus.trap_cause = cause_q;
         end
         default: ;
      endcase
   end

`ifdef MULTICYCLE_PERF_EN
   // Free-running performance counters, wrapping modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.cyc_cnt     <= '0;
         bus.instret_cnt <= '0;
         bus.stall_cnt   <= '0;
      end else begin
         if ((state != RST) && (state != HALT) && (state != TRAP)) begin
            bus.cyc_cnt <= bus.cyc_cnt + 32'd1;
         end
         if ((state != RST) && (state != FETCH) && (next_state == FETCH)) begin
            bus.instret_cnt <= bus.instret_cnt + 32'd1;
         end
         if (waiting && !bus.mem_ready) begin
            bus.stall_cnt <= bus.stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: drives decoder/memory inputs on
// the falling edge and checks the full control vector each cycle against
// hand-written per-state expectations.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   multicycle_ctrl_if bus();

   multicycle_ctrl #(
      .TMO_CYC (64),
      .TMO_W   (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Observed control vector, same layout as mk() below.
   logic [19:0] obs;
   assign obs = {bus.pc_wr_en, bus.ir_wr_en, bus.reg_wr_en, bus.mem_req,
                 bus.mem_we, bus.mem_addr_sel, bus.alu_a_sel, bus.alu_b_sel,
                 bus.alu_op_sel, bus.wb_sel, bus.pc_src, bus.halted,
                 bus.trap, bus.trap_cause};

   function automatic logic [19:0] mk(
      input logic pcw, input logic irw, input logic rw, input logic req,
      input logic we, input logic as, input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] op, input logic [1:0] wb, input logic [1:0] ps,
      input logic h, input logic t, input logic [1:0] c);
      return {pcw, irw, rw, req, we, as, a, b, op, wb, ps, h, t, c};
   endfunction

   logic [19:0] e_fetch_wait, e_fetch_rdy, e_decode, e_ex_r, e_ex_i, e_wb_alu;
   logic [19:0] e_mem_addr, e_mem_rd, e_wb_mem, e_mem_wr, e_br_t, e_br_n;
   logic [19:0] e_jal, e_jalr, e_halt, e_trap_ill, e_trap_tmo;

   task automatic checkOutput(input string tag, input logic [19:0] got, input logic [19:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%05h expected=%05h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [6:0] op, input logic halt,
                                input logic bc, input logic rdy);
      bus.opcode        = op;
      bus.instr_is_halt = halt;
      bus.branch_cond   = bc;
      bus.mem_ready     = rdy;
   endtask

   task automatic step(input string tag, input logic [19:0] exp);
      #1;
      checkOutput(tag, obs, exp);
      @(negedge clk);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      #1;
      checkOutput("rst_assert", obs, 20'h0);
      @(negedge clk);
      rst = 1'b0;
      step("rst_release", 20'h0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      e_fetch_wait = mk(0,0,0,1,0,0,2'd0,2'd1,2'd0,2'd0,2'd0,0,0,2'd0);
      e_fetch_rdy  = mk(1,1,0,1,0,0,2'd0,2'd1,2'd0,2'd0,2'd0,0,0,2'd0);
      e_decode     = mk(0,0,0,0,0,0,2'd2,2'd2,2'd0,2'd0,2'd0,0,0,2'd0);
      e_ex_r       = mk(0,0,0,0,0,0,2'd1,2'd0,2'd2,2'd0,2'd0,0,0,2'd0);
      e_ex_i       = mk(0,0,0,0,0,0,2'd1,2'd2,2'd2,2'd0,2'd0,0,0,2'd0);
      e_wb_alu     = mk(0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0);
      e_mem_addr   = mk(0,0,0,0,0,0,2'd1,2'd2,2'd0,2'd0,2'd0,0,0,2'd0);
      e_mem_rd     = mk(0,0,0,1,0,1,2'd0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0);
      e_wb_mem     = mk(0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd1,2'd0,0,0,2'd0);
      e_mem_wr     = mk(0,0,0,1,1,1,2'd0,2'd0,2'd0,2'd0,2'd0,0,0,2'd0);
      e_br_t       = mk(1,0,0,0,0,0,2'd1,2'd0,2'd1,2'd0,2'd1,0,0,2'd0);
      e_br_n       = mk(0,0,0,0,0,0,2'd1,2'd0,2'd1,2'd0,2'd1,0,0,2'd0);
      e_jal        = mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd2,2'd1,0,0,2'd0);
      e_jalr       = mk(1,0,1,0,0,0,2'd1,2'd2,2'd0,2'd2,2'd2,0,0,2'd0);
      e_halt       = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,1,0,2'd0);
      e_trap_ill   = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0,1,2'd1);
      e_trap_tmo   = mk(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,2'd0,0,1,2'd2);

      applyStimulus(7'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("reset_state", obs, 20'h0);
      @(negedge clk);
      reset_dut();

      // add x3,x1,x2 with zero-wait memory: 4 cycles
      applyStimulus(OP_R, 1'b0, 1'b0, 1'b1);
      step("add_fetch", e_fetch_rdy);
      step("add_decode", e_decode);
      step("add_ex_r", e_ex_r);
      step("add_wb", e_wb_alu);

      // lw with 3 wait cycles in FETCH and in MEM_RD: 11 cycles
      applyStimulus(OP_LOAD, 1'b0, 1'b0, 1'b0);
      repeat (3) step("lw_fetch_wait", e_fetch_wait);
      applyStimulus(OP_LOAD, 1'b0, 1'b0, 1'b1);
      step("lw_fetch_rdy", e_fetch_rdy);
      step("lw_decode", e_decode);
      step("lw_mem_addr", e_mem_addr);
      applyStimulus(OP_LOAD, 1'b0, 1'b0, 1'b0);
      repeat (3) step("lw_mem_rd_wait", e_mem_rd);
      applyStimulus(OP_LOAD, 1'b0, 1'b0, 1'b1);
      step("lw_mem_rd_rdy", e_mem_rd);
      step("lw_wb_mem", e_wb_mem);

      // sw zero-wait: 4 cycles
      applyStimulus(OP_STORE, 1'b0, 1'b0, 1'b1);
      step("sw_fetch", e_fetch_rdy);
      step("sw_decode", e_decode);
      step("sw_mem_addr", e_mem_addr);
      step("sw_mem_wr", e_mem_wr);

      // addi: 4 cycles
      applyStimulus(OP_IMM, 1'b0, 1'b0, 1'b1);
      step("addi_fetch", e_fetch_rdy);
      step("addi_decode", e_decode);
      step("addi_ex_i", e_ex_i);
      step("addi_wb", e_wb_alu);

      // beq taken then not taken: 3 cycles each
      applyStimulus(OP_BRANCH, 1'b0, 1'b1, 1'b1);
      step("beq_t_fetch", e_fetch_rdy);
      step("beq_t_decode", e_decode);
      step("beq_t_branch", e_br_t);
      applyStimulus(OP_BRANCH, 1'b0, 1'b0, 1'b1);
      step("beq_n_fetch", e_fetch_rdy);
      step("beq_n_decode", e_decode);
      step("beq_n_branch", e_br_n);

      // jal and jalr: 3 cycles each
      applyStimulus(OP_JAL, 1'b0, 1'b0, 1'b1);
      step("jal_fetch", e_fetch_rdy);
      step("jal_decode", e_decode);
      step("jal_exec", e_jal);
      applyStimulus(OP_JALR, 1'b0, 1'b0, 1'b1);
      step("jalr_fetch", e_fetch_rdy);
      step("jalr_decode", e_decode);
      step("jalr_exec", e_jalr);

      // halt: absorbing, no further memory requests
      applyStimulus(7'b1110011, 1'b1, 1'b0, 1'b1);
      step("halt_fetch", e_fetch_rdy);
      step("halt_decode", e_decode);
      repeat (4) step("halt_hold", e_halt);

      // illegal opcode 0x7F
      reset_dut();
      applyStimulus(7'h7F, 1'b0, 1'b0, 1'b1);
      step("ill_fetch", e_fetch_rdy);
      step("ill_decode", e_decode);
      repeat (3) step("ill_trap", e_trap_ill);

      // fetch timeout: 64 waiting cycles then TRAP
      reset_dut();
      applyStimulus(OP_R, 1'b0, 1'b0, 1'b0);
      repeat (64) step("tmo_fetch_wait", e_fetch_wait);
      repeat (2) step("tmo_trap", e_trap_tmo);

      // ready on the 64th waiting cycle wins over the timeout
      reset_dut();
      applyStimulus(OP_R, 1'b0, 1'b0, 1'b0);
      repeat (63) step("edge_fetch_wait", e_fetch_wait);
      applyStimulus(OP_R, 1'b0, 1'b0, 1'b1);
      step("edge_fetch_rdy", e_fetch_rdy);
      step("edge_decode", e_decode);
      step("edge_ex_r", e_ex_r);
      step("edge_wb", e_wb_alu);

      // reset pulsed while a store is waiting in MEM_WR
      applyStimulus(OP_STORE, 1'b0, 1'b0, 1'b1);
      step("rstwr_fetch", e_fetch_rdy);
      step("rstwr_decode", e_decode);
      step("rstwr_mem_addr", e_mem_addr);
      applyStimulus(OP_STORE, 1'b0, 1'b0, 1'b0);
      step("rstwr_mem_wr", e_mem_wr);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_memwr", obs, 20'h0);
      @(negedge clk);
      rst = 1'b0;
      step("rst_release_memwr", 20'h0);
      step("fetch_after_rst", e_fetch_wait);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM that sequences a multi-cycle RV32I-subset datapath. The datapath has one shared ALU, one unified instruction/data memory with a ready handshake, and the existing PC register, IR and regfile.
- Drives every write enable, mux select and memory request.
- Replaces per-instruction combinational control with a per-state schedule.
- Sits between the decoder outputs and the datapath muxes of the multi-cycle CPU top.

Parameters:
TMO_CYC, 64, max cycles to wait for mem_ready before trapping (1..255)
TMO_W, 8, width of the timeout counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
opcode  in  7  IR[6:0] from decoder
instr_is_halt  in  1  IR equals package HALT encoding
branch_cond  in  1  branch comparison true (computed outside from rs1/rs2/funct3)
mem_ready  in  1  memory completed current request this cycle
pc_wr_en  out  1  load PC from pc_src mux
ir_wr_en  out  1  load IR/old_pc from memory read data/PC
reg_wr_en  out  1  regfile write
mem_req  out  1  memory request valid
mem_we  out  1  request is a store
mem_addr_sel  out  1  0=PC, 1=ALUOut register
alu_a_sel  out  2  0=PC, 1=rs1, 2=old_pc
alu_b_sel  out  2  0=rs2, 1=const 4, 2=imm_ext
alu_op_sel  out  2  0=ADD, 1=SUB, 2=funct-decoded (alu_ctrl)
wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (already +4)
pc_src  out  2  0=ALU result, 1=ALUOut register, 2=ALU result & ~1
halted  out  1  in HALT state
trap  out  1  in TRAP state
trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout

Behaviour:
- Reset (async, any time, including mid-memory-request): state=RST, all outputs 0, timeout counter 0.
  - RST->FETCH on first clk edge after deassert.
  - An in-flight request is abandoned; the memory side must drop it when mem_req falls.
- FETCH: mem_req=1, mem_addr_sel=0, alu_a=PC, alu_b=4, op=ADD.
  - Stays in FETCH while !mem_ready.
  - On mem_ready: ir_wr_en=1, pc_wr_en=1, pc_src=0, then DECODE.
- DECODE: alu_a=old_pc, alu_b=imm, ADD (target latched in ALUOut). Next state by opcode:
  - instr_is_halt: HALT (takes priority over opcode decode)
  - 0110011: EX_R
  - 0010011: EX_I
  - 0000011 / 0100011: MEM_ADDR
  - 1100011: BRANCH
  - 1101111: JAL
  - 1100111: JALR
  - anything else: TRAP, cause=1
- EX_R: alu_a=rs1, alu_b=rs2, op=2 -> WB_ALU.
- EX_I: alu_a=rs1, alu_b=imm, op=2 -> WB_ALU.
- WB_ALU: reg_wr_en=1, wb_sel=0 -> FETCH.
- MEM_ADDR: alu_a=rs1, alu_b=imm, ADD -> MEM_RD on load, MEM_WR on store.
- MEM_RD: mem_req=1, mem_we=0, addr_sel=1; wait mem_ready -> WB_MEM.
- WB_MEM: reg_wr_en=1, wb_sel=1 -> FETCH.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1; wait mem_ready -> FETCH.
- BRANCH: alu_a=rs1, alu_b=rs2, SUB; pc_wr_en=branch_cond, pc_src=1 -> FETCH.
- JAL: reg_wr_en=1, wb_sel=2, pc_wr_en=1, pc_src=1 -> FETCH.
  - The regfile write uses the PC value before this edge; old PC+4 and the new PC commit together.
- JALR: alu_a=rs1, alu_b=imm, ADD; reg_wr_en=1, wb_sel=2, pc_wr_en=1, pc_src=2 -> FETCH.
- HALT and TRAP: absorbing; all enables 0; exited only by rst.
- Latency with zero-wait memory (mem_ready in the first request cycle), cycles per instruction:
  - R/I: 4
  - load: 5
  - store: 4
  - branch/jal/jalr: 3
  - Each extra wait cycle adds 1.
- Timeout counter:
  - Clears on entry to FETCH/MEM_RD/MEM_WR and increments each waiting cycle.
  - Reaching TMO_CYC without mem_ready -> TRAP, cause=2.
  - mem_ready in the same cycle the count hits TMO_CYC wins (no trap).
- mem_req stays high and stable, with stable addr_sel/we, until mem_ready.
- Outputs are decoded from the state register only (Moore). branch_cond may gate pc_wr_en in BRANCH only.

Optional Feature:
MULTICYCLE_PERF_EN. When defined, the block adds these outputs:
- cyc_cnt: 32-bit, increments every cycle outside RST/HALT/TRAP.
- instret_cnt: 32-bit, increments on each transition into FETCH from a non-RST state.
- stall_cnt: 32-bit, increments on each memory-wait cycle.
- All three counters reset to 0 and wrap modulo 2^32.

Without the macro these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- all_pkgs gains:
  - typedef enum mc_state_e (RST, FETCH, DECODE, EX_R, EX_I, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JAL, JALR, HALT, TRAP)
  - select-encoding localparams (ASEL_*, BSEL_*, AOP_*, WB_*, PCSRC_*)
  - TRAP_* cause codes
  - reuses existing opcode constants and HALT
- One sub-module: mc_mem_timeout (counter plus expiry flag), instantiated once.

Test Plan:
- add x3,x1,x2 (x1=5,x2=7), mem_ready always 1 -> states FETCH,DECODE,EX_R,WB_ALU; reg_wr_en once in cycle 4, wb_sel=0; 4 cycles total.
- lw with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> 11 cycles; mem_req stable through waits; single reg_wr_en with wb_sel=1.
- beq with branch_cond=1 then 0 -> pc_wr_en with pc_src=1 in the BRANCH cycle only when taken; 3 cycles each.
- jalr at PC=0x40, rs1=0x101, imm=0 -> pc_src=2 and reg_wr_en in the same cycle; next fetch occurs, with PC 0x100 produced by the datapath mask.
- opcode 0x7F -> TRAP, cause=1; mem_ready held 0 for TMO_CYC=64 in FETCH -> TRAP, cause=2 at cycle 64; mem_ready at cycle 64 -> no trap.
- rst pulsed mid-MEM_WR -> all outputs 0 immediately; FETCH one cycle after deassert. HALT instruction -> halted=1 with no further mem_req.
